// File: rtl/mem_lsu.sv
// mem_lsu: registered load/store unit for the MEM stage.
// Takes one instruction per handshake from EX and runs one request/acknowledge
// bus transfer per memory op. Byte lanes are big-endian: offset 0 is the MSB lane.
// Load data is aligned and extended. Misaligned accesses, bus errors and bus
// timeouts are reported as RISC-V exceptions.
// Optional feature: define LSU_MISALIGN_EXC_EN to trap misaligned accesses with
// mcause 4/6. Without it, the access is silently truncated to natural alignment.

`ifndef AluOpBus
`define AluOpBus 7:0
`endif
`ifndef RegAddrBus
`define RegAddrBus 4:0
`endif
`ifndef EXE_LB_OP
`define EXE_LB_OP  8'b11100000
`define EXE_LH_OP  8'b11100001
`define EXE_LW_OP  8'b11100011
`define EXE_LBU_OP 8'b11100100
`define EXE_LHU_OP 8'b11100101
`define EXE_LWU_OP 8'b11100110
`define EXE_LD_OP  8'b11100111
`define EXE_SB_OP  8'b11101000
`define EXE_SH_OP  8'b11101001
`define EXE_SW_OP  8'b11101011
`define EXE_SD_OP  8'b11101111
`endif

module mem_lsu #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255,
  localparam int NB     = XLEN / 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush_i,
  input  logic               valid_i,
  input  logic [`AluOpBus]   aluop_i,
  input  logic [XLEN-1:0]    addr_i,
  input  logic [XLEN-1:0]    store_i,
  input  logic [`RegAddrBus] wd_i,
  input  logic               wreg_i,
  input  logic [XLEN-1:0]    result_i,
  output logic               bus_req_o,
  output logic               bus_we_o,
  output logic [XLEN-1:0]    bus_addr_o,
  output logic [NB-1:0]      bus_sel_o,
  output logic [XLEN-1:0]    bus_wdata_o,
  input  logic               bus_ack_i,
  input  logic [XLEN-1:0]    bus_rdata_i,
  output logic               stall_o,
  output logic               valid_o,
  output logic [`RegAddrBus] wd_o,
  output logic               wreg_o,
  output logic [XLEN-1:0]    wdata_o,
  output logic               exc_valid_o,
  output logic [4:0]         exc_code_o,
  output logic [XLEN-1:0]    badaddr_o
);

  localparam int OFFW = $clog2(NB);

  localparam logic [4:0] EXC_LD_MISALIGN = 5'd4;
  localparam logic [4:0] EXC_LD_FAULT    = 5'd5;
  localparam logic [4:0] EXC_ST_MISALIGN = 5'd6;
  localparam logic [4:0] EXC_ST_FAULT    = 5'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state;

  // Decoded view of the incoming op.
  logic       is_mem;
  logic       is_store;
  logic       is_uns;
  logic       unsup;
  logic [1:0] size;      // log2 of access bytes
  logic       misal_exc;

  // Lane/data preparation for the incoming op.
  logic [OFFW-1:0] aoff;
  logic [XLEN-1:0] wdata_rep;
  logic [NB-1:0]   sel_d;
  int              acc_bytes;
  int              lane_shift;

  // State latched at accept for the outstanding access.
  logic [1:0]       size_q;
  logic             uns_q;
  logic             wreg_q;
  logic             killed_q;
  logic [OFFW-1:0]  aoff_q;
  logic [XLEN-1:0]  addr_q;
  logic [15:0]      tmo_cnt;
  logic             valid_q;
  logic             exc_valid_q;

  // Load alignment/extension of the returning bus data.
  logic [XLEN-1:0] ld_sh;
  logic [XLEN-1:0] ld_keep;
  logic [XLEN-1:0] ld_data;
  logic            ld_sign;
  int              ld_bytes;
  int              ld_shift;

  logic accept;

  // Decode the EX op into memory-access attributes.
  // NOTE: every variable gets a default at the top of a combinational block so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    is_mem   = 1'b0;
    is_store = 1'b0;
    is_uns   = 1'b0;
    unsup    = 1'b0;
    size     = 2'd0;
    case (aluop_i)
      `EXE_LB_OP:  is_mem = 1'b1;
      `EXE_LBU_OP: begin is_mem = 1'b1; is_uns = 1'b1; end
      `EXE_LH_OP:  begin is_mem = 1'b1; size = 2'd1; end
      `EXE_LHU_OP: begin is_mem = 1'b1; size = 2'd1; is_uns = 1'b1; end
      `EXE_LW_OP:  begin is_mem = 1'b1; size = 2'd2; end
      `EXE_LWU_OP: begin
        is_mem = (XLEN == 64); unsup = (XLEN != 64); size = 2'd2; is_uns = 1'b1;
      end
      `EXE_LD_OP:  begin is_mem = (XLEN == 64); unsup = (XLEN != 64); size = 2'd3; end
      `EXE_SB_OP:  begin is_mem = 1'b1; is_store = 1'b1; end
      `EXE_SH_OP:  begin is_mem = 1'b1; is_store = 1'b1; size = 2'd1; end
      `EXE_SW_OP:  begin is_mem = 1'b1; is_store = 1'b1; size = 2'd2; end
      `EXE_SD_OP:  begin
        is_mem = (XLEN == 64); unsup = (XLEN != 64); is_store = 1'b1; size = 2'd3;
      end
      default: ;
    endcase
  end

`ifdef LSU_MISALIGN_EXC_EN
  // Natural-alignment violation for the decoded access size.
  assign misal_exc = ((size == 2'd1) && addr_i[0]) ||
                     ((size == 2'd2) && (addr_i[1:0] != 2'b00)) ||
                     ((size == 2'd3) && (addr_i[2:0] != 3'b000));
`else
  assign misal_exc = 1'b0;
`endif

  // Lane select and replicated store data; offset is truncated to alignment.
  always_comb begin
    aoff       = addr_i[OFFW-1:0] & ~OFFW'((1 << size) - 1);
    acc_bytes  = 1 << size;
    lane_shift = NB - acc_bytes - int'(aoff);
    sel_d      = NB'((1 << acc_bytes) - 1) << lane_shift;
    case (size)
      2'd0:    wdata_rep = {NB{store_i[7:0]}};
      2'd1:    wdata_rep = {(NB/2){store_i[15:0]}};
      2'd2:    wdata_rep = {(NB/4){store_i[31:0]}};
      default: wdata_rep = store_i;
    endcase
  end

  // Pull the addressed lanes down to bit 0 and sign/zero extend.
  always_comb begin
    ld_bytes = 1 << size_q;
    ld_shift = NB - ld_bytes - int'(aoff_q);
    ld_sh    = bus_rdata_i >> (8 * ld_shift);
    case (size_q)
      2'd0:    begin ld_keep = XLEN'(8'hFF);          ld_sign = ld_sh[7];      end
      2'd1:    begin ld_keep = XLEN'(16'hFFFF);       ld_sign = ld_sh[15];     end
      2'd2:    begin ld_keep = XLEN'(32'hFFFF_FFFF);  ld_sign = ld_sh[31];     end
      default: begin ld_keep = '1;                    ld_sign = ld_sh[XLEN-1]; end
    endcase
    ld_data = (ld_sh & ld_keep) | ((!uns_q && ld_sign) ? ~ld_keep : '0);
  end

  assign accept = valid_i && !flush_i && is_mem && (state == S_IDLE);

  // Upstream freeze: the accept cycle itself plus the whole BUSY/DONE window.
  assign stall_o = accept || (state != S_IDLE);

  // A flush landing in DONE still kills the instruction sitting there.
  assign valid_o     = valid_q     && !(flush_i && (state == S_DONE));
  assign exc_valid_o = exc_valid_q && !(flush_i && (state == S_DONE));

  // Control FSM with registered bus and write-back outputs.
  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the unit holds no memory arrays, so every register is put in a known state.
      state       <= S_IDLE;
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_addr_o  <= '0;
      bus_sel_o   <= '0;
      bus_wdata_o <= '0;
      valid_q     <= 1'b0;
      wd_o        <= '0;
      wreg_o      <= 1'b0;
      wdata_o     <= '0;
      exc_valid_q <= 1'b0;
      exc_code_o  <= '0;
      badaddr_o   <= '0;
      size_q      <= '0;
      uns_q       <= 1'b0;
      wreg_q      <= 1'b0;
      killed_q    <= 1'b0;
      aoff_q      <= '0;
      addr_q      <= '0;
      tmo_cnt     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          valid_q     <= 1'b0;
          exc_valid_q <= 1'b0;
          exc_code_o  <= '0;
          badaddr_o   <= '0;
          if (valid_i && !flush_i) begin
            wd_o <= wd_i;
            if (is_mem) begin
              bus_we_o    <= is_store;
              bus_addr_o  <= {addr_i[XLEN-1:OFFW], {OFFW{1'b0}}};
              bus_sel_o   <= sel_d;
              bus_wdata_o <= wdata_rep;
              size_q      <= size;
              uns_q       <= is_uns;
              wreg_q      <= wreg_i && !is_store;
              aoff_q      <= aoff;
              addr_q      <= addr_i;
              killed_q    <= 1'b0;
              wreg_o      <= 1'b0;
              if (misal_exc) begin
                state       <= S_DONE;
                valid_q     <= 1'b1;
                exc_valid_q <= 1'b1;
                exc_code_o  <= is_store ? EXC_ST_MISALIGN : EXC_LD_MISALIGN;
                badaddr_o   <= addr_i;
                wdata_o     <= '0;
              end else begin
                state     <= S_BUSY;
                bus_req_o <= 1'b1;
                tmo_cnt   <= '0;
              end
            end else begin
              // Pass-through: unsupported memory ops never write a register.
              valid_q <= 1'b1;
              wreg_o  <= wreg_i && !unsup;
              wdata_o <= result_i;
            end
          end
        end

        S_BUSY: begin
          if (flush_i) killed_q <= 1'b1;
          if (bus_ack_i) begin
            // Ack has priority over a timeout expiring in the same cycle.
            bus_req_o <= 1'b0;
            state     <= S_DONE;
            valid_q   <= !(killed_q || flush_i);
            wreg_o    <= wreg_q;
            wdata_o   <= bus_we_o ? '0 : ld_data;
          end else if (tmo_cnt == 16'(TIMEOUT - 1)) begin
            bus_req_o   <= 1'b0;
            state       <= S_DONE;
            valid_q     <= !(killed_q || flush_i);
            exc_valid_q <= !(killed_q || flush_i);
            exc_code_o  <= bus_we_o ? EXC_ST_FAULT : EXC_LD_FAULT;
            badaddr_o   <= addr_q;
            wreg_o      <= 1'b0;
            wdata_o     <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
        end

        S_DONE: begin
          valid_q     <= 1'b0;
          exc_valid_q <= 1'b0;
          state       <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu at XLEN=32, TIMEOUT=4: directed cases from the
// block's behaviour list followed by randomized operations against a byte-level model.

`ifndef AluOpBus
`define AluOpBus 7:0
`endif
`ifndef RegAddrBus
`define RegAddrBus 4:0
`endif
`ifndef EXE_LB_OP
`define EXE_LB_OP  8'b11100000
`define EXE_LH_OP  8'b11100001
`define EXE_LW_OP  8'b11100011
`define EXE_LBU_OP 8'b11100100
`define EXE_LHU_OP 8'b11100101
`define EXE_LWU_OP 8'b11100110
`define EXE_LD_OP  8'b11100111
`define EXE_SB_OP  8'b11101000
`define EXE_SH_OP  8'b11101001
`define EXE_SW_OP  8'b11101011
`define EXE_SD_OP  8'b11101111
`endif

module tb_mem_lsu;

  localparam int TMO = 4;
  localparam logic [7:0] OP_ADD = 8'h20;

  logic        clk = 1'b0;
  logic        rst, flush_i, valid_i, wreg_i, bus_ack_i;
  logic [7:0]  aluop_i;
  logic [31:0] addr_i, store_i, result_i, bus_rdata_i;
  logic [4:0]  wd_i;
  logic        bus_req_o, bus_we_o, stall_o, valid_o, wreg_o, exc_valid_o;
  logic [31:0] bus_addr_o, bus_wdata_o, wdata_o, badaddr_o;
  logic [3:0]  bus_sel_o;
  logic [4:0]  wd_o, exc_code_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_lsu #(.XLEN(32), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i), .valid_i(valid_i), .aluop_i(aluop_i),
    .addr_i(addr_i), .store_i(store_i), .wd_i(wd_i), .wreg_i(wreg_i), .result_i(result_i),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_sel_o(bus_sel_o), .bus_wdata_o(bus_wdata_o), .bus_ack_i(bus_ack_i),
    .bus_rdata_i(bus_rdata_i), .stall_o(stall_o), .valid_o(valid_o), .wd_o(wd_o),
    .wreg_o(wreg_o), .wdata_o(wdata_o), .exc_valid_o(exc_valid_o),
    .exc_code_o(exc_code_o), .badaddr_o(badaddr_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Op attributes at XLEN=32: nb=0 means no bus access.
  function automatic void decode(input logic [7:0] op, output int nb, output bit st,
                                 output bit uns, output bit wr_ok);
    nb = 0; st = 0; uns = 0; wr_ok = 1;
    case (op)
      `EXE_LB_OP:  nb = 1;
      `EXE_LBU_OP: begin nb = 1; uns = 1; end
      `EXE_LH_OP:  nb = 2;
      `EXE_LHU_OP: begin nb = 2; uns = 1; end
      `EXE_LW_OP:  nb = 4;
      `EXE_SB_OP:  begin nb = 1; st = 1; end
      `EXE_SH_OP:  begin nb = 2; st = 1; end
      `EXE_SW_OP:  begin nb = 4; st = 1; end
      `EXE_LD_OP, `EXE_SD_OP, `EXE_LWU_OP: wr_ok = 0;
      default: ;
    endcase
  endfunction

  // Byte at address offset o lives in lane 3-o (big-endian).
  function automatic logic [3:0] exp_sel(input logic [31:0] a, input int nb);
    logic [3:0] s = '0;
    for (int i = 0; i < nb; i++) s[3 - (int'(a % 4) + i)] = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] exp_rep(input logic [31:0] st, input int nb);
    logic [63:0] w = 64'(st) & ((64'd1 << (8 * nb)) - 1);
    logic [63:0] r = '0;
    for (int k = 0; k < 4 / nb; k++) r |= w << (8 * nb * k);
    return r[31:0];
  endfunction

  function automatic logic [31:0] exp_load(input logic [31:0] rd, input logic [31:0] a,
                                           input int nb, input bit uns);
    logic [63:0] v = '0;
    for (int i = 0; i < nb; i++) begin
      int o = int'(a % 4) + i;
      v = (v << 8) | 64'((rd >> (24 - 8 * o)) & 32'hFF);
    end
    if (!uns && v[8 * nb - 1]) v |= ~((64'd1 << (8 * nb)) - 1);
    return v[31:0];
  endfunction

  // One instruction end to end. ack_wait: BUSY cycle index of the ack (<0 or >=TMO
  // means none). fmode: 0 none, 1 flush in first BUSY cycle, 2 flush in DONE.
  task automatic run(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] st,
                     input logic [31:0] res, input logic [4:0] wd, input logic wr,
                     input int ack_wait, input logic [31:0] rdata, input int fmode);
    int nb; bit st_op, uns, wr_ok, exc_exp;
    logic [31:0] a_al;
    decode(op, nb, st_op, uns, wr_ok);
    valid_i = 1; aluop_i = op; addr_i = addr; store_i = st; result_i = res;
    wd_i = wd; wreg_i = wr;
    @(negedge clk);
    chk("accept_stall", stall_o, nb != 0);
    @(posedge clk); #1;
    valid_i = 0; addr_i = $urandom(); store_i = $urandom(); wd_i = 5'($urandom());
    if (nb == 0) begin
      @(negedge clk);
      chk("pass_valid", valid_o, 1);
      chk("pass_wdata", wdata_o, res);
      chk("pass_wreg", wreg_o, wr && wr_ok);
      chk("pass_wd", wd_o, wd);
      chk("pass_stall", stall_o, 0);
      chk("pass_req", bus_req_o, 0);
      @(posedge clk); #1;
      return;
    end
`ifdef LSU_MISALIGN_EXC_EN
    if ((addr % nb) != 0) begin
      @(negedge clk);
      chk("mis_valid", valid_o, 1);
      chk("mis_exc", exc_valid_o, 1);
      chk("mis_code", exc_code_o, st_op ? 5'd6 : 5'd4);
      chk("mis_badaddr", badaddr_o, addr);
      chk("mis_wreg", wreg_o, 0);
      chk("mis_req", bus_req_o, 0);
      @(posedge clk); #1;
      chk("mis_idle_valid", valid_o, 0);
      return;
    end
`endif
    a_al = addr - (addr % nb);
    exc_exp = 1;
    for (int k = 0; k < TMO; k++) begin
      bus_ack_i = (k == ack_wait);
      bus_rdata_i = (k == ack_wait) ? rdata : $urandom();
      if (fmode == 1 && k == 0) flush_i = 1;
      @(negedge clk);
      chk("busy_req", bus_req_o, 1);
      chk("busy_stall", stall_o, 1);
      chk("busy_valid", valid_o, 0);
      if (k == 0) begin
        chk("bus_sel", bus_sel_o, exp_sel(a_al, nb));
        chk("bus_addr", bus_addr_o, a_al & ~32'd3);
        chk("bus_we", bus_we_o, st_op);
        if (st_op) chk("bus_wdata", bus_wdata_o, exp_rep(st, nb));
      end
      @(posedge clk); #1;
      flush_i = 0;
      if (k == ack_wait) begin exc_exp = 0; break; end
    end
    bus_ack_i = 0;
    if (fmode == 2) flush_i = 1;
    @(negedge clk);
    chk("done_req", bus_req_o, 0);
    chk("done_stall", stall_o, 1);
    if (fmode != 0) begin
      chk("flush_valid", valid_o, 0);
      chk("flush_exc", exc_valid_o, 0);
    end else begin
      chk("done_valid", valid_o, 1);
      chk("done_exc", exc_valid_o, exc_exp);
      if (exc_exp) begin
        chk("fault_code", exc_code_o, st_op ? 5'd7 : 5'd5);
        chk("fault_badaddr", badaddr_o, addr);
        chk("fault_wreg", wreg_o, 0);
      end else begin
        chk("done_wreg", wreg_o, st_op ? 1'b0 : wr);
        chk("done_wd", wd_o, wd);
        if (!st_op) chk("load_data", wdata_o, exp_load(rdata, a_al, nb, uns));
      end
    end
    @(posedge clk); #1;
    flush_i = 0;
    chk("idle_valid", valid_o, 0);
    chk("idle_stall", stall_o, 0);
  endtask

  logic [7:0] ops [12] = '{`EXE_LB_OP, `EXE_LBU_OP, `EXE_LH_OP, `EXE_LHU_OP, `EXE_LW_OP,
                           `EXE_SB_OP, `EXE_SH_OP, `EXE_SW_OP, `EXE_LD_OP, `EXE_SD_OP,
                           `EXE_LWU_OP, OP_ADD};

  initial begin
    rst = 1; flush_i = 0; valid_i = 0; aluop_i = '0; addr_i = '0; store_i = '0;
    wd_i = '0; wreg_i = 0; result_i = '0; bus_ack_i = 0; bus_rdata_i = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_bus", {bus_req_o, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o}, '0);
    chk("rst_wb", {valid_o, wreg_o, wd_o, wdata_o}, '0);
    chk("rst_exc", {exc_valid_o, exc_code_o, badaddr_o}, '0);
    chk("rst_stall", stall_o, 0);
    rst = 0;

    // LB at 0x103, two wait cycles, sign-extended 0xF0.
    run(`EXE_LB_OP, 32'h103, 32'h0, 32'h0, 5'd3, 1, 2, 32'h0000_00F0, 0);
    // SH at 0x202: lanes 0011, data replicated.
    run(`EXE_SH_OP, 32'h202, 32'h1234_ABCD, 32'h0, 5'd4, 1, 0, 32'h0, 0);
    // Word at an unaligned address: trapped or truncated depending on build.
    run(`EXE_LW_OP, 32'h1002, 32'h0, 32'h0, 5'd5, 1, 1, 32'h8765_4321, 0);
    // Store that never sees ack, then one acked on the last allowed cycle.
    run(`EXE_SW_OP, 32'h300, 32'hDEAD_BEEF, 32'h0, 5'd6, 0, -1, 32'h0, 0);
    run(`EXE_SW_OP, 32'h304, 32'hCAFE_F00D, 32'h0, 5'd6, 0, TMO - 1, 32'h0, 0);
    // Load timeout gives code 5; unsigned half-word load.
    run(`EXE_LH_OP, 32'h402, 32'h0, 32'h0, 5'd7, 1, -1, 32'h0, 0);
    run(`EXE_LHU_OP, 32'h400, 32'h0, 32'h0, 5'd8, 1, 0, 32'hF00D_1234, 0);
    // 64-bit-only ops and an ALU op pass straight through.
    run(`EXE_LD_OP, 32'h1008, 32'h0, 32'h1111_2222, 5'd9, 1, 0, 32'h0, 0);
    run(`EXE_SD_OP, 32'h1008, 32'h5, 32'h3333_4444, 5'd10, 1, 0, 32'h0, 0);
    run(`EXE_LWU_OP, 32'h1004, 32'h0, 32'h5555_6666, 5'd11, 1, 0, 32'h0, 0);
    run(OP_ADD, 32'h0, 32'h0, 32'h7777_8888, 5'd12, 1, 0, 32'h0, 0);
    // Flush during BUSY with ack 3 cycles later; flush landing in DONE.
    run(`EXE_LW_OP, 32'h500, 32'h0, 32'h0, 5'd13, 1, 3, 32'h1234_5678, 1);
    run(`EXE_LB_OP, 32'h501, 32'h0, 32'h0, 5'd14, 1, 0, 32'h00FF_0000, 2);

    // Flush in the accept cycle: nothing is taken.
    valid_i = 1; flush_i = 1; aluop_i = `EXE_LW_OP; addr_i = 32'h10;
    @(negedge clk);
    chk("idle_flush_stall", stall_o, 0);
    @(posedge clk); #1;
    valid_i = 0; flush_i = 0;
    @(negedge clk);
    chk("idle_flush_req", bus_req_o, 0);
    chk("idle_flush_valid", valid_o, 0);
    @(posedge clk); #1;

    // Reset in the middle of a transfer drops the request at the next edge.
    valid_i = 1; aluop_i = `EXE_LW_OP; addr_i = 32'h20; wreg_i = 1;
    @(posedge clk); #1;
    valid_i = 0;
    @(negedge clk);
    chk("pre_rst_req", bus_req_o, 1);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk("mid_rst_req", bus_req_o, 0);
    chk("mid_rst_stall", stall_o, 0);
    chk("mid_rst_valid", valid_o, 0);

    for (int n = 0; n < 60; n++) begin
      run(ops[$urandom_range(0, 11)], $urandom() & 32'hFFFF, $urandom(), $urandom(),
          5'($urandom()), 1'($urandom()), $urandom_range(0, 5), $urandom(),
          ($urandom_range(0, 7) == 0) ? 1 : 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_lsu.md
# mem_lsu

Parametrised, registered load/store unit for the MEM stage, and the successor to the combinational memory-access stage. It accepts one instruction per handshake from EX and drives a request/acknowledge data bus with byte-lane selects. It aligns and extends load data, and raises RISC-V misaligned and access-fault exceptions, including a bus timeout. Results and exceptions leave registered toward WB and the CSR/exception logic. `stall_o` freezes the upstream pipeline while a bus transaction is outstanding.

## Interface
- XLEN, 32: data/address width, 32 or 64. LD/SD/LWU are legal only at 64.
- TIMEOUT, 255: maximum bus-wait cycles before an access fault. Must be 1..2^16-1.
- NB, XLEN/8: byte lanes (derived).

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high.
- flush_i  in  1  kill the current instruction (exception/mret commit)
- valid_i  in  1  EX instruction valid
- aluop_i  in  `AluOpBus`  operation (EXE_LB/LBU/LH/LHU/LW/LWU/LD/SB/SH/SW/SD_OP, others pass through)
- addr_i  in  XLEN  effective address
- store_i  in  XLEN  store data (rs2)
- wd_i  in  `RegAddrBus`  destination register
- wreg_i  in  1  register write enable
- result_i  in  XLEN  ALU result for non-memory ops
- bus_req_o  out  1  bus request
- bus_we_o  out  1  write
- bus_addr_o  out  XLEN  word-aligned address (low log2(NB) bits zero)
- bus_sel_o  out  NB  byte enables
- bus_wdata_o  out  XLEN  lane-replicated store data
- bus_ack_i  in  1  transfer complete; rdata valid in the same cycle
- bus_rdata_i  in  XLEN  read data
- stall_o  out  1  hold EX/ID/IF
- valid_o  out  1  result valid toward WB
- wd_o  out  `RegAddrBus`
- wreg_o  out  1
- wdata_o  out  XLEN  write-back data
- exc_valid_o  out  1  exception, pulses together with valid_o
- exc_code_o  out  5  mcause code: 4/6 misaligned load/store, 5/7 load/store access fault
- badaddr_o  out  XLEN  faulting address (mtval)

## Operation
- FSM states are IDLE, BUSY and DONE.
- Lane order is big-endian: address offset 0 maps to the MSB lane. For example, at XLEN=32, SB at offset 0 gives sel 4'b1000. At XLEN=64, offset 0 gives sel 8'h80.
- Natural alignment is required: half-word at addr[0]=0, word at addr[1:0]=0, double-word at addr[2:0]=0.
- Store data is replicated across all lanes (byte×NB, half×NB/2, word×NB/4).
- Load data is extracted from the selected lanes. It is sign-extended for LB/LH/LW/LD and zero-extended for LBU/LHU/LWU.
- In IDLE with valid_i and a memory op:
  - Address, select, write data, op and destination are latched.
  - If the access is misaligned (see Configuration), the FSM goes to DONE with an exception.
  - Otherwise it goes to BUSY.
- Non-memory ops in IDLE register result_i into wdata_o. valid_o is asserted the next cycle with no stall.
- In BUSY, bus_req_o and all bus_* outputs stay stable until bus_ack_i.
  - On ack, rdata is captured and the FSM goes to DONE.
  - A store in BUSY forces wreg_o to 0.
- In DONE, valid_o (plus exc_* if faulted) is asserted for exactly one cycle, then the FSM returns to IDLE.
- A timeout counter is cleared on entry to BUSY and increments each BUSY cycle without ack.
  - When it reaches TIMEOUT, the FSM deasserts bus_req_o, moves to DONE, and flags the access fault with badaddr_o equal to the byte address.
- When an exception is flagged, wreg_o is forced to 0.
- Unsupported ops at XLEN=32 (LD/SD/LWU) are treated as non-memory pass-through with wreg_o=0.

## Timing
- Reset values: every output is 0 and the state is IDLE.
- stall_o:
  - High combinationally in the IDLE cycle that accepts a memory op.
  - Stays high in all BUSY cycles and in DONE.
  - Low in IDLE otherwise.
- Latency:
  - Non-memory op: 1 cycle.
  - Memory op with zero-wait ack: accept (cycle 0), BUSY with req (cycle 1), ack in cycle 1, valid_o in cycle 2.
- Flush:
  - flush_i in IDLE or DONE drops the instruction: no valid_o, return to IDLE.
  - flush_i in BUSY cannot abort the bus. The request is held until ack or timeout, then valid_o is suppressed and no exception is raised.
- If ack and timeout occur in the same cycle, ack wins and no fault is raised.
- rst mid-transaction drops bus_req_o on the next edge. The bus slave must tolerate this.

## Configuration
- `LSU_MISALIGN_EXC_EN` defined:
  - Misaligned accesses issue no bus request.
  - DONE follows the accept cycle directly, with exc_code_o 4 (load) or 6 (store) and badaddr_o equal to addr_i.
- `LSU_MISALIGN_EXC_EN` undefined:
  - Misaligned accesses are not detected.
  - The address is truncated to alignment and the access is performed at the aligned lanes.

## Test plan
- XLEN=32, LB at 0x103, rdata 0x000000F0 with ack after 2 wait cycles -> bus_sel_o 4'b0001 and wdata_o 0xFFFFFFF0. valid_o asserts 4 cycles after accept, with stall_o high throughout.
- XLEN=32, SH at 0x202, store_i 0x1234ABCD -> bus_sel_o 4'b0011, bus_wdata_o 0xABCDABCD, bus_we_o 1, wreg_o 0.
- XLEN=64, LD at 0x1008 with rdata 0x8000000000000001 -> sel 8'hFF and wdata_o equal to rdata. LWU at 0x1004 with rdata 0xFFFFFFFF_00000000 -> wdata_o 0x0000000000000000.
- With `LSU_MISALIGN_EXC_EN`, LW at 0x1002 -> no bus_req_o, exc_code_o 4, badaddr_o 0x1002, wreg_o 0, valid_o 1 cycle after accept.
- TIMEOUT=4, SW with ack never asserted -> bus_req_o high for exactly 4 cycles, then exc_code_o 7. A variant with ack arriving on the 4th cycle -> no fault.
- flush_i during BUSY, ack arriving 3 cycles later -> bus_req_o held until ack, and valid_o and exc_valid_o both stay 0.
